alu_cmd_sequencer: RTL and testbench

//  Upstream feeder for the 4-bit combinational ALU. It accepts a nibble stream over a

---
 rtl/alu_cmd_sequencer.sv | 151 +++++++++++++++
 tb/tb_alu_cmd_sequencer.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_sequencer.sv
// Command sequencer that feeds a 4-bit combinational ALU.
// It collects op/A/B nibbles, runs one execute cycle, and hands off the registered result.
module alu_cmd_sequencer #(
    parameter int WIDTH = 4,
    parameter int OPW   = 2,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [OPW-1:0]   alu_op,
    input  logic [WIDTH-1:0] alu_ans,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic [OPW-1:0]   res_op,
    output logic [CNT_W-1:0] cmd_cnt
);

    typedef enum logic [2:0] {
        S_GET_OP = 3'd0,
        S_GET_A  = 3'd1,
        S_GET_B  = 3'd2,
        S_EXEC   = 3'd3,
        S_OUT    = 3'd4
    } state_e;

    state_e           state_q, state_d;
    logic             in_ready_q, in_ready_d;
    logic             res_valid_q, res_valid_d;
    logic [WIDTH-1:0] alu_a_q, alu_a_d;
    logic [WIDTH-1:0] alu_b_q, alu_b_d;
    logic [OPW-1:0]   alu_op_q, alu_op_d;
    logic [WIDTH-1:0] res_data_q, res_data_d;
    logic [OPW-1:0]   res_op_q, res_op_d;
    logic [CNT_W-1:0] cmd_cnt_q, cmd_cnt_d;
    logic             accept_s;
    logic             res_take_s;

    // Handshakes qualify on the registered ready/valid, so control never depends combinationally on inputs.
    assign accept_s   = in_valid & in_ready_q;
    assign res_take_s = res_ready & res_valid_q;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_GET_OP;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_GET_OP: begin
                if (accept_s) state_d = S_GET_A;
                else          state_d = S_GET_OP;
            end
            S_GET_A: begin
                if (accept_s) state_d = S_GET_B;
                else          state_d = S_GET_A;
            end
            S_GET_B: begin
                if (accept_s) state_d = S_EXEC;
                else          state_d = S_GET_B;
            end
            S_EXEC:  state_d = S_OUT;
            S_OUT: begin
                if (res_take_s) state_d = S_GET_OP;
                else            state_d = S_OUT;
            end
            default: state_d = S_GET_OP;
        endcase
    end

    // Output and datapath next values; ready/valid are decoded from the next state so they stay registered.
    always_comb begin
        alu_a_d    = alu_a_q;
        alu_b_d    = alu_b_q;
        alu_op_d   = alu_op_q;
        res_data_d = res_data_q;
        res_op_d   = res_op_q;
        cmd_cnt_d  = cmd_cnt_q;
        case (state_q)
            S_GET_OP: begin
                if (accept_s) alu_op_d = in_data[OPW-1:0];
                else          alu_op_d = alu_op_q;
            end
            S_GET_A: begin
                if (accept_s) alu_a_d = in_data;
                else          alu_a_d = alu_a_q;
            end
            S_GET_B: begin
                if (accept_s) alu_b_d = in_data;
                else          alu_b_d = alu_b_q;
            end
            S_EXEC: begin
                res_data_d = alu_ans;
                res_op_d   = alu_op_q;
            end
            S_OUT: begin
                if (res_take_s) cmd_cnt_d = cmd_cnt_q + CNT_W'(1);
                else            cmd_cnt_d = cmd_cnt_q;
            end
            default: begin
                cmd_cnt_d = cmd_cnt_q;
            end
        endcase
        in_ready_d  = (state_d == S_GET_OP) || (state_d == S_GET_A) || (state_d == S_GET_B);
        res_valid_d = (state_d == S_OUT);
    end

    // Datapath and handshake registers; all clear on reset so a pending result is dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready_q  <= 1'b0;
            res_valid_q <= 1'b0;
            alu_a_q     <= {WIDTH{1'b0}};
            alu_b_q     <= {WIDTH{1'b0}};
            alu_op_q    <= {OPW{1'b0}};
            res_data_q  <= {WIDTH{1'b0}};
            res_op_q    <= {OPW{1'b0}};
            cmd_cnt_q   <= {CNT_W{1'b0}};
        end else begin
            in_ready_q  <= in_ready_d;
            res_valid_q <= res_valid_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_op_q    <= alu_op_d;
            res_data_q  <= res_data_d;
            res_op_q    <= res_op_d;
            cmd_cnt_q   <= cmd_cnt_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign res_valid = res_valid_q;
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_op    = alu_op_q;
    assign res_data  = res_data_q;
    assign res_op    = res_op_q;
    assign cmd_cnt   = cmd_cnt_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed self-checking bench for alu_cmd_sequencer with a combinational ALU stub.
module tb_alu_cmd_sequencer;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_data;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [1:0] alu_op;
    logic [3:0] alu_ans;
    logic       res_valid;
    logic       res_ready;
    logic [3:0] res_data;
    logic [1:0] res_op;
    logic [7:0] cmd_cnt;

    int n_checks;
    int n_fail;
    int cyc;

    alu_cmd_sequencer #(.WIDTH(4), .OPW(2), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_ans(alu_ans),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_op(res_op), .cmd_cnt(cmd_cnt)
    );

    always_comb begin
        case (alu_op)
            2'b00:   alu_ans = alu_a + alu_b;
            2'b01:   alu_ans = alu_a - alu_b;
            2'b10:   alu_ans = alu_a & alu_b;
            default: alu_ans = alu_a | alu_b;
        endcase
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_in_ready"}, {31'd0, in_ready}, 32'd0);
        check_eq({tag, "_res_valid"}, {31'd0, res_valid}, 32'd0);
        check_eq({tag, "_res_data"}, {28'd0, res_data}, 32'd0);
        check_eq({tag, "_res_op"}, {30'd0, res_op}, 32'd0);
        check_eq({tag, "_alu_a"}, {28'd0, alu_a}, 32'd0);
        check_eq({tag, "_alu_b"}, {28'd0, alu_b}, 32'd0);
        check_eq({tag, "_alu_op"}, {30'd0, alu_op}, 32'd0);
        check_eq({tag, "_cmd_cnt"}, {24'd0, cmd_cnt}, 32'd0);
    endtask

    // Present one nibble and return 1 time unit after the edge that accepts it.
    task automatic send_nibble(input string tag, input logic [3:0] d);
        int waited;
        in_valid = 1'b1;
        in_data  = d;
        waited   = 0;
        while (!in_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) check_eq({tag, "_accept_timeout"}, {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Feed op/A/B and check the result appears exactly two edges after B.
    task automatic run_cmd(input string tag, input logic [3:0] op, input logic [3:0] a,
                           input logic [3:0] b, input logic [3:0] exp_d, input logic [1:0] exp_op);
        send_nibble(tag, op);
        send_nibble(tag, a);
        send_nibble(tag, b);
        check_eq({tag, "_exec_no_valid"}, {31'd0, res_valid}, 32'd0);
        check_eq({tag, "_exec_in_ready"}, {31'd0, in_ready}, 32'd0);
        @(posedge clk);
        #1;
        check_eq({tag, "_res_valid"}, {31'd0, res_valid}, 32'd1);
        check_eq({tag, "_res_data"}, {28'd0, res_data}, {28'd0, exp_d});
        check_eq({tag, "_res_op"}, {30'd0, res_op}, {30'd0, exp_op});
    endtask

    task automatic finish_cmd(input string tag, input logic [7:0] exp_cnt);
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        check_eq({tag, "_valid_drop"}, {31'd0, res_valid}, 32'd0);
        check_eq({tag, "_cmd_cnt"}, {24'd0, cmd_cnt}, {24'd0, exp_cnt});
    endtask

    task automatic pulse_reset(input string tag);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_all_zero(tag);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_eq({tag, "_ready_after_release"}, {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        int         done;
        int         cmd;
        int         beat;
        int         guard;
        int         last_cyc;
        logic [3:0] hold_data;
        logic [3:0] exp_r;
        n_checks  = 0;
        n_fail    = 0;
        cyc       = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 4'h0;
        res_ready = 1'b1;

        // 1: reset values, then op=3 A=1 B=1 -> or = 1
        #12;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_eq("ready_after_release", {31'd0, in_ready}, 32'd1);
        run_cmd("t1", 4'h3, 4'h1, 4'h1, 4'h1, 2'b11);
        finish_cmd("t1", 8'd1);

        // 2: add wrap and sub borrow
        run_cmd("t2_add", 4'h0, 4'hF, 4'h2, 4'h1, 2'b00);
        finish_cmd("t2_add", 8'd2);
        run_cmd("t2_sub", 4'h1, 4'h0, 4'h1, 4'hF, 2'b01);
        finish_cmd("t2_sub", 8'd3);

        // 3: result back-pressure with a nibble waiting
        res_ready = 1'b0;
        run_cmd("t3", 4'h2, 4'hC, 4'hA, 4'h8, 2'b10);
        in_valid = 1'b1;
        in_data  = 4'h5;
        hold_data = res_data;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check_eq("t3_hold_valid", {31'd0, res_valid}, 32'd1);
            check_eq("t3_hold_data", {28'd0, res_data}, {28'd0, hold_data});
            check_eq("t3_hold_ready", {31'd0, in_ready}, 32'd0);
            check_eq("t3_hold_cnt", {24'd0, cmd_cnt}, 32'd3);
        end
        check_eq("t3_no_consume_op", {30'd0, alu_op}, 32'd2);
        check_eq("t3_no_consume_a", {28'd0, alu_a}, 32'hC);
        in_valid = 1'b0;
        finish_cmd("t3", 8'd4);

        // 4: bubbles between beats; upper op bits ignored
        @(posedge clk); #1;
        send_nibble("t4", 4'hE);
        @(posedge clk); #1;
        check_eq("t4_op", {30'd0, alu_op}, 32'd2);
        send_nibble("t4", 4'h6);
        @(posedge clk); #1;
        check_eq("t4_a", {28'd0, alu_a}, 32'h6);
        send_nibble("t4", 4'h3);
        check_eq("t4_b", {28'd0, alu_b}, 32'h3);
        @(posedge clk); #1;
        check_eq("t4_res_valid", {31'd0, res_valid}, 32'd1);
        check_eq("t4_res_data", {28'd0, res_data}, 32'h2);
        check_eq("t4_res_op", {30'd0, res_op}, 32'd2);
        finish_cmd("t4", 8'd5);

        // 5: reset in GET_B with A loaded, then in OUT with a pending result
        send_nibble("t5a", 4'h0);
        send_nibble("t5a", 4'h9);
        check_eq("t5_a_loaded", {28'd0, alu_a}, 32'h9);
        pulse_reset("t5_rst_getb");
        run_cmd("t5b", 4'h0, 4'h3, 4'h4, 4'h7, 2'b00);
        finish_cmd("t5b", 8'd1);
        res_ready = 1'b0;
        run_cmd("t5c", 4'h3, 4'h5, 4'hA, 4'hF, 2'b11);
        pulse_reset("t5_rst_out");
        res_ready = 1'b1;
        run_cmd("t5d", 4'h1, 4'h8, 4'h3, 4'h5, 2'b01);
        finish_cmd("t5d", 8'd1);

        // 6: 256 back-to-back adds, A = index, B = 1
        pulse_reset("t6_rst");
        res_ready = 1'b1;
        in_valid  = 1'b1;
        done      = 0;
        cmd       = 0;
        beat      = 0;
        guard     = 0;
        last_cyc  = 0;
        while (done < 256 && guard < 3000) begin
            @(negedge clk);
            guard++;
            if (res_valid && res_ready) begin
                exp_r = 4'(done) + 4'h1;
                check_eq("t6_res_data", {28'd0, res_data}, {28'd0, exp_r});
                if (done > 0) check_eq("t6_period", cyc - last_cyc, 32'd5);
                if (done == 255) check_eq("t6_cnt_255", {24'd0, cmd_cnt}, 32'd255);
                last_cyc = cyc;
                done++;
            end
            if (cmd < 256) begin
                in_valid = 1'b1;
                in_data  = (beat == 0) ? 4'h0 : ((beat == 1) ? 4'(cmd) : 4'h1);
                if (in_ready) begin
                    beat++;
                    if (beat == 3) begin
                        beat = 0;
                        cmd++;
                    end
                end
            end else begin
                in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
        check_eq("t6_all_done", done, 32'd256);
        @(posedge clk);
        #1;
        check_eq("t6_cnt_wrap", {24'd0, cmd_cnt}, 32'd0);
        check_eq("t6_idle_valid", {31'd0, res_valid}, 32'd0);
        check_eq("t6_idle_ready", {31'd0, in_ready}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
